pri_req_gen: RTL and testbench



---
 rtl/pri_req_gen.sv | 140 ++++++++++++++
 tb/tb_pri_req_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pri_req_gen.sv
// Request-side producer for the pSLIP priority selector: per-output/per-class VOQ occupancy
// counters, highest-class encode, and a LOAD/ISSUE/WAIT handshake that captures the winner vector.
module pri_req_gen #(
  parameter int N  = 16,
  parameter int P  = 4,
  parameter int C  = $clog2(P),
  parameter int D  = 15,
  parameter int TO = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_valid,
  input  logic [$clog2(N)-1:0] enq_port,
  input  logic [C-1:0]         enq_cls,
  input  logic                 deq_valid,
  input  logic [$clog2(N)-1:0] deq_port,
  input  logic [C-1:0]         deq_cls,
  input  logic                 start,
  input  logic                 ready_in,
  input  logic [C*N-1:0]       sel_in,
  output logic [C*N-1:0]       pri_out,
  output logic                 update,
  output logic [C*N-1:0]       win,
  output logic                 busy,
  output logic                 done,
  output logic                 tout,
  output logic                 ovf,
  output logic                 udf
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(D + 1);
  localparam int TW = $clog2(TO + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

  state_t state, state_nxt;

  logic [N-1:0][P-1:1][CW-1:0] cnt, cnt_nxt;
  logic                        ovf_nxt, udf_nxt;
  logic                        inc_hit, dec_hit;
  logic [C*N-1:0]              code;
  logic [TW-1:0]               tcnt, tcnt_nxt;
  logic                        load_en, cap_en, to_fire;

  // A matched enqueue/dequeue on one counter cancels out, so neither flag can fire.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    udf_nxt = 1'b0;
    inc_hit = 1'b0;
    dec_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 1; k < P; k++) begin
        inc_hit = enq_valid && (enq_port == PW'(i)) && (enq_cls == C'(k));
        dec_hit = deq_valid && (deq_port == PW'(i)) && (deq_cls == C'(k));
        if (inc_hit && !dec_hit) begin
          if (cnt[i][k] == CW'(D)) ovf_nxt = 1'b1;
          else                     cnt_nxt[i][k] = cnt[i][k] + CW'(1);
        end else if (dec_hit && !inc_hit) begin
          if (cnt[i][k] == '0) udf_nxt = 1'b1;
          else                 cnt_nxt[i][k] = cnt[i][k] - CW'(1);
        end
      end
    end
  end

  // Ascending scan so the highest non-empty class wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 1; k < P; k++) begin
        if (cnt[i][k] != '0) code[i*C +: C] = C'(k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    load_en   = 1'b0;
    cap_en    = 1'b0;
    to_fire   = 1'b0;
    update    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        update    = 1'b1;
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ready_in) begin
          cap_en    = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
          if (tcnt_nxt == TW'(TO)) begin
            to_fire   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      pri_out <= '0;
      win     <= '0;
      done    <= 1'b0;
      tout    <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
      if (load_en) pri_out <= code;
      if (cap_en)  win     <= sel_in;
      done  <= cap_en;
      tout  <= to_fire;
    end
  end

endmodule

// File: tb/tb_pri_req_gen.sv
// Scoreboard bench for pri_req_gen: expected priority/winner vectors are queued when driven
// and compared when update/done appear.
module tb_pri_req_gen;
  localparam int N = 16;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enq_valid = 1'b0, deq_valid = 1'b0;
  logic [3:0]     enq_port = '0, deq_port = '0;
  logic [C-1:0]   enq_cls = '0, deq_cls = '0;
  logic           start = 1'b0, ready_in = 1'b0;
  logic [C*N-1:0] sel_in = '0;
  logic [C*N-1:0] pri_out, win;
  logic           update, busy, done, tout, ovf, udf;

  pri_req_gen dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_port(enq_port), .enq_cls(enq_cls),
    .deq_valid(deq_valid), .deq_port(deq_port), .deq_cls(deq_cls),
    .start(start), .ready_in(ready_in), .sel_in(sel_in),
    .pri_out(pri_out), .update(update), .win(win), .busy(busy),
    .done(done), .tout(tout), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int upd_n = 0;
  logic [C*N-1:0] pq[$];
  logic [C*N-1:0] wq[$];
  logic [C*N-1:0] last_win = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: pops expectations when the DUT presents results.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (update) begin
        upd_n++;
        if (pq.size() == 0) chk("update_unexpected", 64'(update), 64'd0);
        else                chk("pri_out", 64'(pri_out), 64'(pq.pop_front()));
      end
      if (done) begin
        if (wq.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else                chk("win", 64'(win), 64'(wq.pop_front()));
      end
    end
  end

  task automatic ev(input bit e, input bit d, input logic [3:0] p, input logic [C-1:0] c);
    enq_valid = e; deq_valid = d;
    enq_port = p;  deq_port = p;
    enq_cls = c;   deq_cls = c;
    tick();
    enq_valid = 1'b0; deq_valid = 1'b0;
  endtask

  // Drives one round with an in-bench selector model that answers 3 cycles after update.
  task automatic run_round(input logic [C*N-1:0] exp_pri, input bit give_rdy,
                           input bit disturb, input bit poke_start,
                           output int lat, output bit got_done, output bit got_tout);
    int s;
    int cd;
    logic [C*N-1:0] sel;
    lat = -1; got_done = 1'b0; got_tout = 1'b0; cd = 0;
    pq.push_back(exp_pri);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      enq_valid = disturb && (k < 2);
      enq_port  = 4'd7;
      enq_cls   = 2'd3;
      start     = poke_start && (k == 3);
      ready_in  = 1'b0;
      if (cd != 0) begin
        cd--;
        if (cd == 0 && give_rdy) begin
          sel = C*N'($urandom);
          sel_in = sel;
          ready_in = 1'b1;
          wq.push_back(sel);
          last_win = sel;
        end
      end
      if (update) cd = 3;
      tick();
      if (done || tout) begin
        lat = cyc - s;
        got_done = done;
        got_tout = tout;
        break;
      end
    end
    ready_in = 1'b0; enq_valid = 1'b0; start = 1'b0;
    if (lat < 0) chk("round_no_end", 64'd0, 64'd1);
    else         chk("pri_hold", 64'(pri_out), 64'(exp_pri));
  endtask

  task automatic nominal(input string tag, input logic [C*N-1:0] exp_pri, input bit disturb);
    int lat; bit gd, gt; int u0;
    u0 = upd_n;
    run_round(exp_pri, 1'b1, disturb, 1'b0, lat, gd, gt);
    chk({tag, "_lat"}, 64'(lat), 64'd6);
    chk({tag, "_done"}, 64'({gd, gt}), 64'b10);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_pulse"}, 64'({done, update}), 64'd0);
    chk({tag, "_upd_once"}, 64'(upd_n - u0), 64'd1);
  endtask

  initial begin
    int lat; bit gd, gt;
    tick(); tick();
    chk("rst_pri", 64'(pri_out), 64'd0);
    chk("rst_win", 64'(win), 64'd0);
    chk("rst_flags", 64'({update, busy, done, tout, ovf, udf}), 64'd0);
    reset = 1'b1;
    tick();

    nominal("empty", 32'h0, 1'b0);

    for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 4'd2, 2'd1);
    ev(1'b1, 1'b0, 4'd2, 2'd3);
    ev(1'b1, 1'b0, 4'd3, 2'd0);
    chk("cls0_no_flag", 64'({ovf, udf}), 64'd0);
    ev(1'b0, 1'b1, 4'd3, 2'd0);
    chk("cls0_deq_no_flag", 64'({ovf, udf}), 64'd0);
    nominal("basic", 32'h30, 1'b0);

    // Hand-driven round with a fixed winner.
    begin
      logic [C*N-1:0] w;
      w = 32'h30;
      pq.push_back(32'h30);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("upd_at_t2", 64'(update), 64'd1);
      tick();
      chk("upd_one_cycle", 64'(update), 64'd0);
      tick(); tick();
      ready_in = 1'b1; sel_in = w; wq.push_back(w); last_win = w;
      tick();
      ready_in = 1'b0;
      chk("fixed_done", 64'({done, busy}), 64'b10);
      chk("fixed_win", 64'(win), 64'h30);
      tick();
    end

    for (int i = 0; i < 15; i++) begin
      ev(1'b1, 1'b0, 4'd0, 2'd2);
      chk("fill_no_ovf", 64'(ovf), 64'd0);
    end
    ev(1'b1, 1'b0, 4'd0, 2'd2);
    chk("ovf_fire", 64'(ovf), 64'd1);
    tick();
    chk("ovf_pulse", 64'(ovf), 64'd0);
    ev(1'b1, 1'b1, 4'd0, 2'd2);
    chk("full_both_no_flag", 64'({ovf, udf}), 64'd0);
    nominal("full", 32'h32, 1'b0);
    for (int i = 0; i < 15; i++) begin
      ev(1'b0, 1'b1, 4'd0, 2'd2);
      chk("drain_no_udf", 64'(udf), 64'd0);
    end
    ev(1'b0, 1'b1, 4'd0, 2'd2);
    chk("drain_udf", 64'(udf), 64'd1);

    ev(1'b0, 1'b1, 4'd5, 2'd1);
    chk("udf_fire", 64'({ovf, udf}), 64'b01);
    tick();
    chk("udf_pulse", 64'(udf), 64'd0);
    ev(1'b1, 1'b1, 4'd5, 2'd1);
    chk("empty_both_no_flag", 64'({ovf, udf}), 64'd0);
    ev(1'b1, 1'b0, 4'd5, 2'd1);
    nominal("p5", 32'h430, 1'b0);
    ev(1'b0, 1'b1, 4'd5, 2'd1);
    nominal("p5_gone", 32'h30, 1'b0);

    // Arrivals after LOAD must not leak into the round in progress.
    nominal("snap", 32'h30, 1'b1);
    nominal("snap_next", 32'hC030, 1'b0);
    ev(1'b0, 1'b1, 4'd7, 2'd3);
    ev(1'b0, 1'b1, 4'd7, 2'd3);

    run_round(32'h30, 1'b0, 1'b0, 1'b1, lat, gd, gt);
    chk("to_lat", 64'(lat), 64'd18);
    chk("to_flags", 64'({gd, gt}), 64'b01);
    chk("to_win_kept", 64'(win), 64'(last_win));
    tick();
    chk("to_pulse_idle", 64'({tout, busy}), 64'd0);
    nominal("after_to", 32'h30, 1'b0);

    pq.push_back(32'h30);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("wait_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_pri", 64'(pri_out), 64'd0);
    chk("mid_rst_win", 64'(win), 64'd0);
    chk("mid_rst_flags", 64'({update, busy, done, tout, ovf, udf}), 64'd0);
    reset = 1'b1;
    ready_in = 1'b1; sel_in = '1;
    tick();
    chk("late_rdy_no_done", 64'({done, busy}), 64'd0);
    tick();
    ready_in = 1'b0;
    chk("late_rdy_win", 64'({done, win}), 64'd0);
    nominal("post_rst", 32'h0, 1'b0);

    chk("pq_empty", 64'(pq.size()), 64'd0);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
